// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and sizes for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned WAIT_W     = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WB,
    GRANT_FIFO
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, long-latency, issue, hazard-query and register-file signals.
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_accept;

  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0]       lu_data;
  logic                  lu_ready;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  stall_pipe;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_a3;
  logic [XLEN-1:0]       rf_wd;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           issue_valid, issue_rd, rs1, rs2,
    input  wb_accept, lu_ready, rs1_busy, rs2_busy, stall_pipe,
           rf_we, rf_a3, rf_wd, busy_mask
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
           issue_valid, issue_rd, rs1, rs2,
    output wb_accept, lu_ready, rs1_busy, rs2_busy, stall_pipe,
           rf_we, rf_a3, rf_wd, busy_mask
  );

endinterface

// File: rtl/regfile_write_arbiter_rf_wr_fifo.sv
// Small power-of-two FIFO holding pending long-latency register writes.
module rf_wr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t din,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wr_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and a buffered long-latency unit.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  wr_req_t             fifo_din;
  wr_req_t             fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                stall;
  logic                wb_live;
  grant_e              grant;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  assign fifo_din  = '{rd: bus.lu_rd, data: bus.lu_data};
  assign fifo_push = bus.lu_valid && !fifo_full;
  assign fifo_pop  = (grant == GRANT_FIFO);

  rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign stall   = !fifo_empty && (wait_cnt == WAIT_LIMIT);
  assign wb_live = bus.wb_valid && (bus.wb_rd != '0);

  always_comb begin
    grant = GRANT_NONE;
    if (stall)            grant = GRANT_FIFO;
    else if (wb_live)     grant = GRANT_WB;
    else if (!fifo_empty) grant = GRANT_FIFO;
  end

  // x0 entries still pop from the FIFO but never assert the write enable.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_a3 = '0;
    bus.rf_wd = '0;
    case (grant)
      GRANT_WB: begin
        bus.rf_we = 1'b1;
        bus.rf_a3 = bus.wb_rd;
        bus.rf_wd = bus.wb_data;
      end
      GRANT_FIFO: begin
        bus.rf_we = (fifo_head.rd != '0);
        bus.rf_a3 = fifo_head.rd;
        bus.rf_wd = fifo_head.data;
      end
      default: ;
    endcase
  end

  assign bus.wb_accept  = bus.wb_valid && !stall;
  assign bus.stall_pipe = stall;
  assign bus.lu_ready   = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst)                       wait_cnt <= '0;
    else if (fifo_empty || fifo_pop) wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Set is applied after clear so a new issue wins over a same-cycle completion.
  always_comb begin
    busy_next = busy;
    if (fifo_pop) busy_next[fifo_head.rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) busy_next[bus.issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign bus.busy_mask = busy;
  assign bus.rs1_busy  = busy[bus.rs1];
  assign bus.rs2_busy  = busy[bus.rs2];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (FIFO_DEPTH=2, MAX_WAIT=4).
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset.rf_we got=%0h exp=0", bus.rf_we); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset.lu_ready got=%0h exp=1", bus.lu_ready); end
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("FAIL reset.busy_mask got=%h exp=0", bus.busy_mask); end
    checks++; if (bus.stall_pipe !== 1'b0) begin errors++; $display("FAIL reset.stall got=%0h exp=0", bus.stall_pipe); end
    cyc();
  endtask

  task automatic test_issue_complete();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    cyc();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd5; bus.rs2 = 5'd4;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd5; bus.lu_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.busy_mask !== 32'h20) begin errors++; $display("FAIL issue.busy_mask got=%h exp=00000020", bus.busy_mask); end
    checks++; if (bus.rs1_busy !== 1'b1) begin errors++; $display("FAIL issue.rs1_busy got=%0h exp=1", bus.rs1_busy); end
    checks++; if (bus.rs2_busy !== 1'b0) begin errors++; $display("FAIL issue.rs2_busy got=%0h exp=0", bus.rs2_busy); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL issue.push_rf_we got=%0h exp=0", bus.rf_we); end
    cyc();
    bus.lu_valid = 1'b0;
    #1;
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL issue.pop_rf_we got=%0h exp=1", bus.rf_we); end
    checks++; if (bus.rf_a3 !== 5'd5) begin errors++; $display("FAIL issue.pop_rf_a3 got=%0d exp=5", bus.rf_a3); end
    checks++; if (bus.rf_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL issue.pop_rf_wd got=%h exp=deadbeef", bus.rf_wd); end
    cyc();
    checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("FAIL issue.cleared got=%h exp=0", bus.busy_mask); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL issue.idle_rf_we got=%0h exp=0", bus.rf_we); end
  endtask

  task automatic test_starvation();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_data = 32'h77;
    cyc();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (bus.wb_accept !== 1'b1 || bus.stall_pipe !== 1'b0 || bus.rf_a3 !== 5'd3)
        begin errors++; $display("FAIL starve.wb_cycle%0d got accept=%0h stall=%0h a3=%0d exp accept=1 stall=0 a3=3", i, bus.wb_accept, bus.stall_pipe, bus.rf_a3); end
      cyc();
    end
    #1;
    checks++; if (bus.stall_pipe !== 1'b1) begin errors++; $display("FAIL starve.stall got=%0h exp=1", bus.stall_pipe); end
    checks++; if (bus.wb_accept !== 1'b0) begin errors++; $display("FAIL starve.wb_accept got=%0h exp=0", bus.wb_accept); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd7 || bus.rf_wd !== 32'h77)
      begin errors++; $display("FAIL starve.forced got we=%0h a3=%0d wd=%h exp we=1 a3=7 wd=00000077", bus.rf_we, bus.rf_a3, bus.rf_wd); end
    cyc();
    #1;
    checks++; if (bus.stall_pipe !== 1'b0 || bus.wb_accept !== 1'b1 || bus.rf_a3 !== 5'd3 || bus.rf_wd !== 32'h33)
      begin errors++; $display("FAIL starve.wb_after got stall=%0h accept=%0h a3=%0d wd=%h exp stall=0 accept=1 a3=3 wd=00000033", bus.stall_pipe, bus.wb_accept, bus.rf_a3, bus.rf_wd); end
    cyc();
    idle();
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0)
      begin errors++; $display("FAIL starve.drained got we=%0h busy=%h exp we=0 busy=0", bus.rf_we, bus.busy_mask); end
  endtask

  task automatic test_fifo_full();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h1111;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd10; bus.lu_data = 32'hA;
    #1;
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL full.ready0 got=%0h exp=1", bus.lu_ready); end
    cyc();
    bus.lu_rd = 5'd11; bus.lu_data = 32'hB;
    #1;
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL full.ready1 got=%0h exp=1", bus.lu_ready); end
    cyc();
    bus.lu_rd = 5'd12; bus.lu_data = 32'hC;
    for (int i = 2; i <= 4; i++) begin
      #1;
      checks++; if (bus.lu_ready !== 1'b0 || bus.stall_pipe !== 1'b0)
        begin errors++; $display("FAIL full.held_cycle%0d got ready=%0h stall=%0h exp ready=0 stall=0", i, bus.lu_ready, bus.stall_pipe); end
      cyc();
    end
    #1;
    checks++; if (bus.stall_pipe !== 1'b1 || bus.rf_a3 !== 5'd10 || bus.lu_ready !== 1'b0)
      begin errors++; $display("FAIL full.forced got stall=%0h a3=%0d ready=%0h exp stall=1 a3=10 ready=0", bus.stall_pipe, bus.rf_a3, bus.lu_ready); end
    cyc();
    #1;
    checks++; if (bus.lu_ready !== 1'b1 || bus.stall_pipe !== 1'b0 || bus.rf_a3 !== 5'd3)
      begin errors++; $display("FAIL full.reopen got ready=%0h stall=%0h a3=%0d exp ready=1 stall=0 a3=3", bus.lu_ready, bus.stall_pipe, bus.rf_a3); end
    cyc();
    idle();
    #1;
    checks++; if (bus.rf_a3 !== 5'd11 || bus.rf_wd !== 32'hB || bus.lu_ready !== 1'b0)
      begin errors++; $display("FAIL full.drain_b got a3=%0d wd=%h ready=%0h exp a3=11 wd=0000000b ready=0", bus.rf_a3, bus.rf_wd, bus.lu_ready); end
    cyc();
    checks++; if (bus.rf_a3 !== 5'd12 || bus.rf_wd !== 32'hC || bus.lu_ready !== 1'b1)
      begin errors++; $display("FAIL full.drain_c got a3=%0d wd=%h ready=%0h exp a3=12 wd=0000000c ready=1", bus.rf_a3, bus.rf_wd, bus.lu_ready); end
    cyc();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL full.empty_rf_we got=%0h exp=0", bus.rf_we); end
  endtask

  task automatic test_x0();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'h55;
    #1;
    checks++; if (bus.wb_accept !== 1'b1) begin errors++; $display("FAIL x0.wb_accept got=%0h exp=1", bus.wb_accept); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL x0.wb_rf_we got=%0h exp=0", bus.rf_we); end
    cyc();
    idle();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd0; bus.lu_data = 32'h99;
    cyc();
    idle();
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0)
      begin errors++; $display("FAIL x0.lu_pop got we=%0h busy=%h exp we=0 busy=0", bus.rf_we, bus.busy_mask); end
    cyc();
  endtask

  task automatic test_set_wins();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cyc();
    idle();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd9; bus.lu_data = 32'h99;
    cyc();
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    #1;
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd9)
      begin errors++; $display("FAIL setwins.pop got we=%0h a3=%0d exp we=1 a3=9", bus.rf_we, bus.rf_a3); end
    cyc();
    idle();
    #1;
    checks++; if (bus.busy_mask !== 32'h200) begin errors++; $display("FAIL setwins.busy got=%h exp=00000200", bus.busy_mask); end
  endtask

  task automatic test_mid_reset();
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h3;
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd20; bus.lu_data = 32'h2020;
    cyc();
    bus.lu_valid = 1'b0;
    #1;
    checks++; if (bus.busy_mask !== 32'h200 || bus.rf_a3 !== 5'd3)
      begin errors++; $display("FAIL rst.before got busy=%h a3=%0d exp busy=00000200 a3=3", bus.busy_mask, bus.rf_a3); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0 || bus.lu_ready !== 1'b1)
      begin errors++; $display("FAIL rst.after got we=%0h busy=%h ready=%0h exp we=0 busy=0 ready=1", bus.rf_we, bus.busy_mask, bus.lu_ready); end
    cyc();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst.still_empty got=%0h exp=0", bus.rf_we); end
  endtask

  initial begin
    idle();
    test_reset();
    test_issue_complete();
    test_starvation();
    test_fifo_full();
    test_x0();
    test_set_wins();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
